// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// instruction classes and the datapath mux/select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_IALU   = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_JAL    = 3'd5,
        C_LUI    = 3'd6,
        C_ILL    = 3'd7
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] ASA_PC    = 2'd0;
    localparam logic [1:0] ASA_RS1   = 2'd1;
    localparam logic [1:0] ASA_OLDPC = 2'd2;

    localparam logic [1:0] ASB_RS2  = 2'd0;
    localparam logic [1:0] ASB_IMM  = 2'd1;
    localparam logic [1:0] ASB_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode decode into instruction class, immediate format
// and legality flag.
module opcode_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output iclass_t    o_class,
    output logic [2:0] o_imm_sel,
    output logic       o_legal
);

    always_comb begin
        o_class   = C_ILL;
        o_imm_sel = IMM_I;
        o_legal   = 1'b1;
        unique case (i_opcode)
            OP_R:      o_class = C_R;
            OP_IALU:   o_class = C_IALU;
            OP_LOAD:   o_class = C_LOAD;
            OP_STORE: begin
                o_class   = C_STORE;
                o_imm_sel = IMM_S;
            end
            OP_BRANCH: begin
                o_class   = C_BRANCH;
                o_imm_sel = IMM_B;
            end
            OP_JAL: begin
                o_class   = C_JAL;
                o_imm_sel = IMM_J;
            end
            OP_LUI: begin
                o_class   = C_LUI;
                o_imm_sel = IMM_U;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing the shared datapath.
// CTRL_PERF_CNT_EN adds cycle/instret counters; otherwise they read 0.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             br_cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             pc_src,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t     r_state;
    state_t     w_next;
    iclass_t    w_class;
    logic [2:0] w_imm;
    logic       w_legal;
    logic       w_unused;

    assign w_unused = ^instr[31:7];

    opcode_class_dec u_dec (
        .i_opcode  (instr[6:0]),
        .o_class   (w_class),
        .o_imm_sel (w_imm),
        .o_legal   (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        adr_src   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_src    = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_a = ASA_PC;
        alu_src_b = ASB_RS2;
        alu_op    = ALU_ADD;
        imm_sel   = IMM_I;
        illegal   = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ASB_FOUR;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_sel   = w_imm;
                alu_src_a = ASA_OLDPC;
                alu_src_b = ASB_IMM;
                w_next    = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                imm_sel = w_imm;
                w_next  = S_FETCH;
                unique case (w_class)
                    C_R: begin
                        alu_src_a = ASA_RS1;
                        alu_op    = ALU_FUNCT;
                        w_next    = S_WB;
                    end
                    C_IALU: begin
                        alu_src_a = ASA_RS1;
                        alu_src_b = ASB_IMM;
                        alu_op    = ALU_FUNCT;
                        w_next    = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_a = ASA_RS1;
                        alu_src_b = ASB_IMM;
                        w_next    = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_src_a = ASA_RS1;
                        alu_op    = ALU_SUB;
                        pc_src    = 1'b1;
                        pc_we     = br_cond;
                    end
                    C_JAL: begin
                        pc_we  = 1'b1;
                        pc_src = 1'b1;
                        reg_we = 1'b1;
                        wb_sel = WB_PC4;
                    end
                    C_LUI: begin
                        reg_we = 1'b1;
                        wb_sel = WB_IMM;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                imm_sel = w_imm;
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_we  = (w_class == C_STORE);
                if (mem_ready)
                    w_next = (w_class == C_STORE) ? S_FETCH : S_WB;
            end
            S_WB: begin
                imm_sel = w_imm;
                reg_we  = 1'b1;
                wb_sel  = (w_class == C_LOAD) ? WB_MEM : WB_ALU;
                w_next  = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;

    // An instruction retires when control returns to FETCH from its tail.
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state inside {S_EXEC, S_MEM, S_WB});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (r_state != S_TRAP) r_cycle <= r_cycle + CNT_W'(1);
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl with a memory/IR
// responder, a per-instruction reference model and a separate monitor.
module tb_multicycle_ctrl;

    localparam int N = 40;

    typedef struct packed {
        logic [7:0] cyc;
        logic [1:0] fetch_b;
        logic [5:0] dec;
        logic [2:0] imm_dec;
        logic       imm_hold;
        logic [5:0] ex;
        logic [1:0] n_reg;
        logic [1:0] wb;
        logic [1:0] n_pc;
        logic       pcs;
        logic [1:0] n_wr;
        logic [1:0] n_rd;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        br_cond;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, pc_src;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
    logic [2:0]  imm_sel;
    logic        illegal;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [18:0] w_outs;

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t sb[$];
    int   fwait_q[$];
    int   mwait_q[$];
    logic [31:0] iq[$];
    bit   bq[$];

    always #5 clk = ~clk;

    assign w_outs = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, pc_src,
                     wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel, illegal};

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .br_cond     (br_cond),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .adr_src     (adr_src),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .reg_we      (reg_we),
        .pc_src      (pc_src),
        .wb_sel      (wb_sel),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .imm_sel     (imm_sel),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Class 0..6 = R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI
    function automatic rec_t exp_rec(int c, bit bc, int cyc);
        rec_t e;
        e          = '0;
        e.cyc      = 8'(cyc);
        e.fetch_b  = 2'd2;
        e.dec      = 6'b10_01_00;
        e.imm_hold = 1'b1;
        case (c)
            0: begin e.ex = 6'b01_00_10; e.n_reg = 1; e.wb = 0; end
            1: begin e.ex = 6'b01_01_10; e.n_reg = 1; e.wb = 0; end
            2: begin
                e.ex = 6'b01_01_00; e.n_reg = 1; e.wb = 1; e.n_rd = 1;
            end
            3: begin e.imm_dec = 3'd1; e.ex = 6'b01_01_00; e.n_wr = 1; end
            4: begin
                e.imm_dec = 3'd2; e.ex = 6'b01_00_01;
                e.n_pc = 2'(bc); e.pcs = bc;
            end
            5: begin
                e.imm_dec = 3'd4; e.n_reg = 1; e.wb = 2;
                e.n_pc = 1; e.pcs = 1'b1;
            end
            default: begin e.imm_dec = 3'd3; e.n_reg = 1; e.wb = 3; end
        endcase
        return e;
    endfunction

    // Memory / IR responder: a per-request wait count, then one ready cycle.
    initial begin
        bit busy;
        bit granted;
        int left;
        busy = 0;
        granted = 0;
        left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy = 0;
                granted = 0;
                mem_ready = 1'b0;
                continue;
            end
            if (granted) begin
                busy = 0;
                granted = 0;
            end
            mem_ready = 1'b0;
            if (mem_req) begin
                if (!busy) begin
                    busy = 1;
                    if (adr_src)
                        left = (mwait_q.size() > 0) ? mwait_q.pop_front() : 0;
                    else
                        left = (fwait_q.size() > 0) ? fwait_q.pop_front() : 0;
                end
                if (left > 0) begin
                    left--;
                end else begin
                    mem_ready = 1'b1;
                    granted = 1;
                    if (!adr_src) begin
                        instr = (iq.size() > 0) ? iq.pop_front() : 32'h7F;
                        br_cond = (bq.size() > 0) ? bq.pop_front() : 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: frames instructions between ir_we pulses and scores them.
    initial begin
        bit   open;
        bit   prev_ill;
        int   k;
        int   nrec;
        rec_t cur;
        rec_t e;
        open = 0;
        prev_ill = 0;
        k = 0;
        nrec = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                open = 0;
                prev_ill = 0;
                continue;
            end
            if (mem_req && !mem_ready)
                check("stall_strobes", 64'({ir_we, pc_we, reg_we}), 64'd0);
            if (mem_req && !adr_src)
                check("fetch_imm_sel", 64'(imm_sel), 64'd0);
            if (open && (ir_we || (illegal && !prev_ill))) begin
                cur.cyc = 8'(k + 1);
                open = 0;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("rec%0d", nrec), 64'(cur), 64'(e));
                end
                nrec++;
            end
            if (ir_we) begin
                open = 1;
                k = 0;
                cur = '0;
                cur.fetch_b = alu_src_b;
                cur.imm_hold = 1'b1;
            end else if (open) begin
                k++;
                if (k == 1) begin
                    cur.dec = {alu_src_a, alu_src_b, alu_op};
                    cur.imm_dec = imm_sel;
                end else if (!(mem_req && !adr_src) &&
                             imm_sel != cur.imm_dec) begin
                    cur.imm_hold = 1'b0;
                end
                if (k == 2) cur.ex = {alu_src_a, alu_src_b, alu_op};
                if (reg_we) begin
                    cur.n_reg = cur.n_reg + 2'd1;
                    cur.wb = wb_sel;
                end
                if (pc_we) begin
                    cur.n_pc = cur.n_pc + 2'd1;
                    cur.pcs = pc_src;
                end
                if (mem_req && adr_src && mem_ready) begin
                    if (mem_we) cur.n_wr = cur.n_wr + 2'd1;
                    else        cur.n_rd = cur.n_rd + 2'd1;
                end
            end
            prev_ill = illegal;
        end
    end

    initial begin
        logic [6:0]  ops[7];
        int          base[7];
        int          fw[N+1];
        int          cls, mw, bad, cyc_exp, t;
        bit          bc;
        logic [31:0] r;
        ops  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
        base = '{4, 4, 5, 4, 3, 3, 3};
        rst_n = 1'b0;
        mem_ready = 1'b0;
        instr = 32'h0;
        br_cond = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 64'(w_outs), 64'd0);
        check("reset_cnt", {cycle_cnt, instret_cnt}, 64'd0);

        for (int i = 0; i <= N; i++) fw[i] = $urandom_range(0, 2);
        cyc_exp = 2;
        for (int i = 0; i <= N; i++) begin
            fwait_q.push_back(fw[i]);
            cyc_exp += fw[i] + 1;
        end
        for (int i = 0; i < N; i++) begin
            cls = $urandom_range(0, 6);
            bc = 1'($urandom_range(0, 1));
            mw = 0;
            if (cls == 2 || cls == 3) begin
                mw = $urandom_range(0, 2);
                mwait_q.push_back(mw);
            end
            r = $urandom();
            iq.push_back({r[31:7], ops[cls]});
            bq.push_back(bc);
            sb.push_back(exp_rec(cls, bc, base[cls] + mw + fw[i+1]));
            cyc_exp += base[cls] - 1 + mw;
        end
        iq.push_back(32'h0000007F);
        bq.push_back(1'b0);
        begin
            rec_t e;
            e = '0;
            e.cyc = 8'd2;
            e.fetch_b = 2'd2;
            e.dec = 6'b10_01_00;
            e.imm_hold = 1'b1;
            sb.push_back(e);
        end

        rst_n = 1'b1;
        t = 0;
        while (t < 3000 && illegal !== 1'b1) begin
            @(negedge clk);
            t++;
        end
        check("trap_reached", 64'(illegal), 64'd1);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (w_outs !== 19'h1) bad++;
        end
        check("trap_sticky", 64'(bad), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
`ifdef CTRL_PERF_CNT_EN
        check("instret_cnt", 64'(instret_cnt), 64'(N));
        check("cycle_cnt", 64'(cycle_cnt), 64'(cyc_exp));
`else
        check("instret_cnt", 64'(instret_cnt), 64'd0);
        check("cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif

        #2 rst_n = 1'b0;
        #1 check("trap_async_rst", 64'(w_outs), 64'd0);
        @(negedge clk);
        check("cnt_after_rst", {cycle_cnt, instret_cnt}, 64'd0);

        fwait_q.push_back(6);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_req_held", 64'({mem_req, adr_src, ir_we}), 64'h4);
        #2 rst_n = 1'b0;
        #1 check("async_drop", 64'(w_outs), 64'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
